// File: rtl/addsub_cnt.sv
// Bounded up/down counter with parallel load, wrap/saturate at LO/HI and a boundary-event pulse.
// Define ADDSUB_CNT_STEP_EN to add the STEP port; otherwise the step size is fixed at 1.
module addsub_cnt #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DATA,
    input  logic [WIDTH-1:0] LO,
    input  logic [WIDTH-1:0] HI,
    input  logic             WRAP,
`ifdef ADDSUB_CNT_STEP_EN
    input  logic [WIDTH-1:0] STEP,
`endif
    output logic [WIDTH-1:0] OUTPUT,
    output logic             AT_LO,
    output logic             AT_HI,
    output logic             EVT
);

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] q_p1;
    logic             evt_p1;
    logic [WIDTH:0]   nxt;

`ifdef ADDSUB_CNT_STEP_EN
    assign step = STEP;
`else
    assign step = WIDTH'(1);
`endif

    // Returns {event, next count}. Compares are widened by one bit so Q+S and LO+S never overflow.
    function automatic logic [WIDTH:0] bound_step(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] s,
        input logic             up,
        input logic             wrap
    );
        logic [WIDTH:0] qx;
        logic [WIDTH:0] sx;
        logic [WIDTH:0] lox;
        logic [WIDTH:0] hix;
        qx  = {1'b0, q};
        sx  = {1'b0, s};
        lox = {1'b0, lo};
        hix = {1'b0, hi};
        if ((lo > hi) || (s == '0)) begin
            bound_step = {1'b0, q};
        end else if (up) begin
            if (qx + sx > hix) bound_step = {1'b1, (wrap ? lo : hi)};
            else               bound_step = {1'b0, q + s};
        end else begin
            if (qx < lox + sx) bound_step = {1'b1, (wrap ? hi : lo)};
            else               bound_step = {1'b0, q - s};
        end
    endfunction

    assign nxt = bound_step(q_p1, LO, HI, step, UP, WRAP);

    // Stage 1: registered count and event pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_p1   <= RST_VAL;
            evt_p1 <= 1'b0;
        end else if (LOAD) begin
            q_p1   <= DATA;
            evt_p1 <= 1'b0;
        end else if (EN) begin
            q_p1   <= nxt[WIDTH-1:0];
            evt_p1 <= nxt[WIDTH];
        end else begin
            evt_p1 <= 1'b0;
        end
    end

    assign OUTPUT = q_p1;
    assign EVT    = evt_p1;
    assign AT_LO  = (q_p1 == LO);
    assign AT_HI  = (q_p1 == HI);

endmodule

// File: tb/tb_addsub_cnt.sv
// Directed and randomized check of addsub_cnt (WIDTH=16, RST_VAL=5) against an integer reference model.
module tb_addsub_cnt;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] RSTV = 16'd5;

    logic             CLK = 1'b0;
    logic             RST, EN, UP, LOAD, WRAP;
    logic [WIDTH-1:0] DATA, LO, HI;
`ifdef ADDSUB_CNT_STEP_EN
    logic [WIDTH-1:0] STEP;
`endif
    logic [WIDTH-1:0] OUTPUT;
    logic             AT_LO, AT_HI, EVT;

    int tests = 0;
    int fails = 0;
    int mq;
    bit mevt;

    addsub_cnt #(.WIDTH(WIDTH), .RST_VAL(RSTV)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DATA(DATA),
        .LO(LO), .HI(HI), .WRAP(WRAP),
`ifdef ADDSUB_CNT_STEP_EN
        .STEP(STEP),
`endif
        .OUTPUT(OUTPUT), .AT_LO(AT_LO), .AT_HI(AT_HI), .EVT(EVT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count as a plain integer and apply the bound rules directly.
    function automatic void model_step();
        int s, lo, hi;
`ifdef ADDSUB_CNT_STEP_EN
        s = int'(STEP);
`else
        s = 1;
`endif
        lo = int'(LO);
        hi = int'(HI);
        mevt = 1'b0;
        if (RST)            mq = int'(RSTV);
        else if (LOAD)      mq = int'(DATA);
        else if (EN && lo <= hi && s != 0) begin
            if (UP) begin
                if (mq + s > hi) begin mq = WRAP ? lo : hi; mevt = 1'b1; end
                else mq = mq + s;
            end else begin
                if (mq < lo + s) begin mq = WRAP ? hi : lo; mevt = 1'b1; end
                else mq = mq - s;
            end
        end
    endfunction

    task automatic cyc(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        chk({tag, "_q"},    32'(OUTPUT), 32'(mq));
        chk({tag, "_evt"},  32'(EVT),    32'(mevt));
        chk({tag, "_atlo"}, 32'(AT_LO),  32'(mq == int'(LO)));
        chk({tag, "_athi"}, 32'(AT_HI),  32'(mq == int'(HI)));
    endtask

    initial begin
        logic [WIDTH-1:0] wrap_q [4];
        logic [WIDTH-1:0] sat_q  [4];
        bit               sat_e  [4];
        wrap_q = '{16'd4, 16'd5, 16'd6, 16'd3};
        sat_q  = '{16'd4, 16'd3, 16'd3, 16'd3};
        sat_e  = '{1'b0, 1'b0, 1'b1, 1'b1};
        mq = 0; mevt = 1'b0;

        // Reset with EN active
        RST = 1; EN = 1; UP = 1; LOAD = 0; WRAP = 1; DATA = 0; LO = 0; HI = 16'hFFFF;
`ifdef ADDSUB_CNT_STEP_EN
        STEP = 16'd1;
`endif
        cyc("rst");
        chk("rst_val", 32'(OUTPUT), 32'd5);
        chk("rst_evt", 32'(EVT), 32'd0);

        // Wrap up 3..6
        RST = 0; LOAD = 1; DATA = 16'd3; LO = 16'd3; HI = 16'd6;
        cyc("ld3");
        LOAD = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("wrap");
            chk("wrap_seq", 32'(OUTPUT), 32'(wrap_q[i]));
            chk("wrap_evtseq", 32'(EVT), 32'(i == 3));
        end

        // Saturate down at LO
        LOAD = 1; DATA = 16'd5; WRAP = 0; UP = 0;
        cyc("ld5");
        LOAD = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("sat");
            chk("sat_seq", 32'(OUTPUT), 32'(sat_q[i]));
            chk("sat_evtseq", 32'(EVT), 32'(sat_e[i]));
        end
        chk("sat_atlo", 32'(AT_LO), 32'd1);

        // Load beats enable; then out-of-range value overflows to LO
        LOAD = 1; EN = 1; DATA = 16'h00FF; LO = 0; HI = 16'hFFFF; UP = 1; WRAP = 1;
        cyc("ldpri");
        chk("ldpri_val", 32'(OUTPUT), 32'h00FF);
        DATA = 16'd10; HI = 16'd6;
        cyc("ld10");
        LOAD = 0;
        cyc("ovf");
        chk("ovf_val", 32'(OUTPUT), 32'd0);
        chk("ovf_evt", 32'(EVT), 32'd1);

        // Full-range wrap both ways
        LOAD = 1; DATA = 16'hFFFF; HI = 16'hFFFF;
        cyc("ldfull");
        LOAD = 0;
        cyc("fullup");
        chk("fullup_val", 32'(OUTPUT), 32'd0);
        UP = 0;
        cyc("fulldn");
        chk("fulldn_val", 32'(OUTPUT), 32'hFFFF);
        chk("fulldn_evt", 32'(EVT), 32'd1);

        // Invalid bounds hold the count
        LO = 16'd7; HI = 16'd2;
        cyc("inval");
        chk("inval_val", 32'(OUTPUT), 32'hFFFF);

`ifdef ADDSUB_CNT_STEP_EN
        LOAD = 1; DATA = 0; LO = 0; HI = 16'd10; WRAP = 0; UP = 1; STEP = 16'd4;
        cyc("ldstep");
        LOAD = 0;
        cyc("st4");  chk("st4_val", 32'(OUTPUT), 32'd4);
        cyc("st8");  chk("st8_val", 32'(OUTPUT), 32'd8);
        cyc("st10"); chk("st10_val", 32'(OUTPUT), 32'd10);
        chk("st10_evt", 32'(EVT), 32'd1);
        STEP = 0;
        cyc("st0");  chk("st0_evt", 32'(EVT), 32'd0);
        STEP = 16'd4; LO = 16'd7; HI = 16'd2;
        cyc("stinv"); chk("stinv_val", 32'(OUTPUT), 32'd10);
`endif

        // Reset mid-count overrides load
        RST = 1; LOAD = 1; DATA = 16'd99; EN = 1;
        cyc("rstmid");
        chk("rstmid_val", 32'(OUTPUT), 32'd5);
        RST = 0; LOAD = 0;

        // Randomized traffic on small bounds so the limits are hit often
        for (int n = 0; n < 400; n++) begin
            RST  = ($urandom_range(0, 49) == 0);
            LOAD = ($urandom_range(0, 7) == 0);
            EN   = ($urandom_range(0, 3) != 0);
            UP   = 1'($urandom);
            WRAP = 1'($urandom);
            DATA = 16'($urandom_range(0, 30));
            LO   = 16'($urandom_range(0, 12));
            HI   = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, 24));
`ifdef ADDSUB_CNT_STEP_EN
            STEP = 16'($urandom_range(0, 5));
`endif
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
